chkgen: RTL and testbench

Frame generator placed directly upstream of the frame checksum checker. It collects N payload bytes from a source that may stall, holding them in an internal buffer. Once the payload is complete it emits one contiguous burst: the N bytes, then the LSByte of their 16-bit sum, then the MSByte. It then drives `valid` low for at least GAP cycles, so that the checker sees a fresh rising edge of `valid` for each frame.

---
 rtl/chkgen.sv | 112 +++++++++++
 tb/tb_chkgen.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/chkgen.sv
// Frame generator: buffers N payload bytes, then emits them as one burst
// followed by their 16-bit sum (LSByte, MSByte) and a GAP-cycle idle gap.
module chkgen #(
  parameter int unsigned N   = 100,
  parameter int unsigned GAP = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_d,
  output logic       valid,
  output logic [7:0] d,
  output logic       busy
);

  localparam int unsigned PW = $clog2(N + 2);
  localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned GW = $clog2(GAP + 1);

  typedef enum logic [1:0] {
    S_FILL,
    S_SEND,
    S_GAP
  } state_t;

  state_t        state;
  logic [7:0]    mem [N];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic [15:0]   sum;
  logic [GW-1:0] gcnt;
  logic          hs;

  assign hs = in_valid && in_ready;

  // Payload buffer; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (hs) begin
      mem[wp[AW-1:0]] <= in_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_FILL;
      wp       <= '0;
      rp       <= '0;
      sum      <= '0;
      gcnt     <= '0;
      in_ready <= 1'b0;
      valid    <= 1'b0;
      d        <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        S_FILL: begin
          in_ready <= 1'b1;
          if (hs) begin
            sum  <= sum + 16'(in_d);
            busy <= 1'b1;
            if (wp == PW'(N - 1)) begin
              // Last byte taken: drop in_ready before the burst starts.
              state    <= S_SEND;
              rp       <= '0;
              in_ready <= 1'b0;
            end else begin
              wp <= wp + PW'(1);
            end
          end
        end
        S_SEND: begin
          valid <= 1'b1;
          if (rp < PW'(N)) begin
            d <= mem[rp[AW-1:0]];
          end else if (rp == PW'(N)) begin
            d <= sum[7:0];
          end else begin
            d <= sum[15:8];
          end
          if (rp == PW'(N + 1)) begin
            state <= S_GAP;
            gcnt  <= '0;
          end else begin
            rp <= rp + PW'(1);
          end
        end
        S_GAP: begin
          valid <= 1'b0;
          d     <= '0;
          if (gcnt == GW'(GAP)) begin
            state    <= S_FILL;
            in_ready <= 1'b1;
            busy     <= 1'b0;
            sum      <= '0;
            wp       <= '0;
            rp       <= '0;
          end else begin
            gcnt <= gcnt + GW'(1);
          end
        end
        default: begin
          state    <= S_FILL;
          in_ready <= 1'b0;
          valid    <= 1'b0;
          d        <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chkgen.sv
// Directed bench for chkgen: N=100 main instance, N=300 wrap instance, N=1 instance.
module tb_chkgen;

  logic       clk;
  logic       rst;
  logic       iv [3];
  logic [7:0] id [3];
  logic       ir [3];
  logic       v  [3];
  logic [7:0] od [3];
  logic       bz [3];

  logic [7:0] oq [3][$];
  int         rise [3];
  int         run [3];
  int         last_run [3];
  logic       pv [3];

  int n_tests = 0;
  int n_fail  = 0;

  chkgen #(.N(100), .GAP(2)) dut (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .in_d(id[0]),
    .valid(v[0]), .d(od[0]), .busy(bz[0])
  );

  chkgen #(.N(300), .GAP(2)) dut_w (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .in_d(id[1]),
    .valid(v[1]), .d(od[1]), .busy(bz[1])
  );

  chkgen #(.N(1), .GAP(2)) dut_1 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .in_d(id[2]),
    .valid(v[2]), .d(od[2]), .busy(bz[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output monitor: collects bytes, counts valid rising edges and run lengths.
  always @(negedge clk) begin
    for (int s = 0; s < 3; s++) begin
      if (v[s] === 1'b1) begin
        oq[s].push_back(od[s]);
        if (pv[s] !== 1'b1) rise[s]++;
        run[s]++;
      end else if (pv[s] === 1'b1) begin
        last_run[s] = run[s];
        run[s] = 0;
      end
      pv[s] = v[s];
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon(input int s);
    oq[s].delete();
    rise[s] = 0;
    run[s] = 0;
    last_run[s] = 0;
  endtask

  task automatic feed(input int s, input int n, input bit ctr, input logic [7:0] cval,
                      input bit bub, input bit hold, output int first_wait);
    int  cnt = 0;
    int  cyc = 0;
    bit  hs;
    first_wait = -1;
    while (cnt < n && cyc < 5000) begin
      iv[s] = bub ? ($urandom_range(0, 2) != 0) : 1'b1;
      id[s] = ctr ? 8'(cnt) : cval;
      hs = (iv[s] === 1'b1) && (ir[s] === 1'b1);
      if (hs && cnt == 0) first_wait = cyc;
      @(negedge clk);
      cyc++;
      if (hs) cnt++;
    end
    if (!hold) iv[s] = 1'b0;
    check("feed_count", cnt, n);
  endtask

  task automatic wait_bytes(input int s, input int n);
    int c = 0;
    while (oq[s].size() < n && c < 3000) begin
      @(negedge clk);
      c++;
    end
    repeat (4) @(negedge clk);
    check("frame_len", oq[s].size(), n);
  endtask

  task automatic check_frame(input int s, input int base, input int n, input bit ctr,
                             input logic [7:0] cval, input logic [7:0] lsb, input logic [7:0] msb);
    int bad = 0;
    logic [7:0] exp_b;
    for (int i = 0; i < n; i++) begin
      exp_b = ctr ? 8'(i) : cval;
      if (oq[s].size() <= base + i || oq[s][base + i] !== exp_b) bad++;
    end
    check("payload_bad", bad, 0);
    check("sum_lsb", (oq[s].size() > base + n) ? int'(oq[s][base + n]) : -1, int'(lsb));
    check("sum_msb", (oq[s].size() > base + n + 1) ? int'(oq[s][base + n + 1]) : -1, int'(msb));
  endtask

  initial begin
    int fw;
    rst = 1'b1;
    for (int s = 0; s < 3; s++) begin
      iv[s] = 1'b0;
      id[s] = 8'h00;
      pv[s] = 1'b0;
      clear_mon(s);
    end

    // Reset state
    #1;
    check("rst_valid", int'(v[0]), 0);
    check("rst_d", int'(od[0]), 0);
    check("rst_in_ready", int'(ir[0]), 0);
    check("rst_busy", int'(bz[0]), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("post_rst_in_ready_low", int'(ir[0]), 0);

    // Frame 0..99, in_valid held high, exact timing
    feed(0, 100, 1'b1, 8'h00, 1'b0, 1'b0, fw);
    check("first_wait", fw, 1);
    check("T_in_ready", int'(ir[0]), 0);
    check("T_valid", int'(v[0]), 0);
    check("T_busy", int'(bz[0]), 1);
    @(negedge clk);
    check("T1_valid", int'(v[0]), 1);
    check("T1_d", int'(od[0]), 0);
    repeat (100) @(negedge clk);
    check("T101_lsb", int'(od[0]), 'h56);
    @(negedge clk);
    check("T102_msb", int'(od[0]), 'h13);
    check("T102_valid", int'(v[0]), 1);
    @(negedge clk);
    check("T103_valid", int'(v[0]), 0);
    check("T103_d", int'(od[0]), 0);
    check("T103_in_ready", int'(ir[0]), 0);
    @(negedge clk);
    check("T104_in_ready", int'(ir[0]), 0);
    check("T104_busy", int'(bz[0]), 1);
    @(negedge clk);
    check("T105_in_ready", int'(ir[0]), 1);
    check("T105_busy", int'(bz[0]), 0);
    wait_bytes(0, 102);
    check_frame(0, 0, 100, 1'b1, 8'h00, 8'h56, 8'h13);
    check("f1_run", last_run[0], 102);

    // 0xFF payload with random bubbles
    clear_mon(0);
    feed(0, 100, 1'b0, 8'hFF, 1'b1, 1'b0, fw);
    wait_bytes(0, 102);
    check_frame(0, 0, 100, 1'b0, 8'hFF, 8'h9C, 8'h63);
    check("bub_run", last_run[0], 102);
    check("bub_rise", rise[0], 1);

    // Back-to-back frames, in_valid held high through SEND/GAP
    clear_mon(0);
    feed(0, 100, 1'b1, 8'h00, 1'b0, 1'b1, fw);
    feed(0, 100, 1'b0, 8'hFF, 1'b0, 1'b0, fw);
    check("b2b_wait", fw, 105);
    wait_bytes(0, 204);
    check_frame(0, 0, 100, 1'b1, 8'h00, 8'h56, 8'h13);
    check_frame(0, 102, 100, 1'b0, 8'hFF, 8'h9C, 8'h63);
    check("b2b_rise", rise[0], 2);

    // Reset in the middle of SEND
    clear_mon(0);
    feed(0, 100, 1'b1, 8'h00, 1'b0, 1'b0, fw);
    repeat (50) @(negedge clk);
    check("send_d49", int'(od[0]), 49);
    rst = 1'b1;
    #1;
    check("send_rst_valid", int'(v[0]), 0);
    check("send_rst_d", int'(od[0]), 0);
    check("send_rst_in_ready", int'(ir[0]), 0);
    check("send_rst_busy", int'(bz[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    clear_mon(0);
    feed(0, 100, 1'b1, 8'h00, 1'b0, 1'b0, fw);
    wait_bytes(0, 102);
    check_frame(0, 0, 100, 1'b1, 8'h00, 8'h56, 8'h13);

    // Reset after 40 bytes in FILL
    clear_mon(0);
    feed(0, 40, 1'b0, 8'h77, 1'b0, 1'b0, fw);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    check("partial_no_out", oq[0].size(), 0);
    check("partial_busy", int'(bz[0]), 0);
    feed(0, 100, 1'b1, 8'h00, 1'b0, 1'b0, fw);
    wait_bytes(0, 102);
    check_frame(0, 0, 100, 1'b1, 8'h00, 8'h56, 8'h13);

    // Checksum wrap with N=300 of 0xFF
    clear_mon(1);
    feed(1, 300, 1'b0, 8'hFF, 1'b0, 1'b0, fw);
    wait_bytes(1, 302);
    check_frame(1, 0, 300, 1'b0, 8'hFF, 8'hD4, 8'h2A);
    check("wrap_run", last_run[1], 302);

    // N=1 frame
    clear_mon(2);
    feed(2, 1, 1'b0, 8'hA5, 1'b0, 1'b0, fw);
    wait_bytes(2, 3);
    check_frame(2, 0, 1, 1'b0, 8'hA5, 8'hA5, 8'h00);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
